// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and constants for the unified memory port arbiter
package mips_mem_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;
  typedef enum logic {GNT_IF, GNT_DM} arb_gnt_t;
  localparam logic [31:0] ARB_ERR_DATA = 32'hDEADBEEF;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the shared memory port
interface mem_port_arbiter_if #(parameter int DW = 32, parameter int AW = 32);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic [DW-1:0]   if_rdata;
  logic            if_ready;
  logic            if_stall;
  logic            dm_req;
  logic            dm_we;
  logic [DW/8-1:0] dm_be;
  logic [AW-1:0]   dm_addr;
  logic [DW-1:0]   dm_wdata;
  logic [DW-1:0]   dm_rdata;
  logic            dm_ready;
  logic            dm_stall;
  logic            err;
  logic            mem_en;
  logic            mem_we;
  logic [DW/8-1:0] mem_be;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            mem_ack;
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, if_stall, dm_rdata, dm_ready, dm_stall, err,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, if_stall, dm_rdata, dm_ready, dm_stall, err,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: combinational winner selection between fetch and data requests
module mem_arb_pick
  import mips_mem_pkg::*;
#(
  parameter bit DM_PRIORITY = 1'b1
) (
  input  logic      if_req_i,
  input  logic      dm_req_i,
  input  arb_gnt_t  last_gnt_i,
  output logic      valid_o,
  output arb_gnt_t  gnt_o
);
  assign valid_o = if_req_i | dm_req_i;
  // A lone requester wins; on a tie DM is preferred unless it won last, else alternate
  always_comb begin
    gnt_o = !(if_req_i & dm_req_i) ? (dm_req_i ? GNT_DM : GNT_IF) :
            (DM_PRIORITY && last_gnt_i != GNT_DM) ? GNT_DM :
            (last_gnt_i == GNT_IF) ? GNT_DM : GNT_IF;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch and data ports
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int TIMEOUT     = 64,
  parameter bit DM_PRIORITY = 1'b1
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int BW = DW / 8;
  localparam int CW = $clog2(TIMEOUT + 2);
  arb_state_t    state_q, state_d;
  arb_gnt_t      last_gnt_q, last_gnt_d, gnt_q, gnt_d, pick_gnt;
  logic          pick_valid, dm_win, timeout_hit, busy, resp;
  logic          we_q, we_d, err_q, err_d;
  logic [BW-1:0] be_q, be_d;
  logic [AW-1:0] addr_q, addr_d, sel_addr;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;

  mem_arb_pick #(.DM_PRIORITY(DM_PRIORITY)) u_pick (
    .if_req_i   (bus.if_req),
    .dm_req_i   (bus.dm_req),
    .last_gnt_i (last_gnt_q),
    .valid_o    (pick_valid),
    .gnt_o      (pick_gnt)
  );

  assign dm_win      = pick_gnt == GNT_DM;
  assign sel_addr    = dm_win ? bus.dm_addr : bus.if_addr;
  assign timeout_hit = (TIMEOUT != 0) && (int'(cnt_q) + 1 >= TIMEOUT);
  assign busy        = state_q == ARB_BUSY;
  assign resp        = state_q == ARB_RESP;

  // Next state: grant and latch in IDLE, wait for ack or timeout in BUSY, one RESP cycle
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    case (state_q)
      ARB_IDLE: if (pick_valid) begin
        state_d    = ARB_BUSY;
        gnt_d      = pick_gnt;
        last_gnt_d = pick_gnt;
        we_d       = dm_win & bus.dm_we;
        be_d       = (dm_win & bus.dm_we) ? bus.dm_be : '1;
        addr_d     = sel_addr & ~AW'(3);
        wdata_d    = dm_win ? bus.dm_wdata : '0;
        cnt_d      = '0;
        err_d      = 1'b0;
      end
      ARB_BUSY: if (bus.mem_ack) begin
        state_d = ARB_RESP;
        rdata_d = we_q ? rdata_q : bus.mem_rdata;
      end else if (timeout_hit) begin
        state_d = ARB_RESP;
        rdata_d = DW'(ARB_ERR_DATA);
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(cnt_q != '1);
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and latched access fields; async reset abandons any access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ARB_IDLE;
      last_gnt_q <= GNT_IF;
      gnt_q      <= GNT_IF;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.mem_en    = busy;
  assign bus.mem_we    = busy & we_q;
  assign bus.mem_be    = busy ? be_q : '0;
  assign bus.mem_addr  = busy ? addr_q : '0;
  assign bus.mem_wdata = busy ? wdata_q : '0;
  assign bus.if_ready  = resp & (gnt_q == GNT_IF);
  assign bus.dm_ready  = resp & (gnt_q == GNT_DM);
  assign bus.err       = resp & err_q;
  assign bus.if_rdata  = rdata_q;
  assign bus.dm_rdata  = rdata_q;
  assign bus.if_stall  = bus.if_req & ~bus.if_ready;
  assign bus.dm_stall  = bus.dm_req & ~bus.dm_ready;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for the unified memory port arbiter
module tb_mem_port_arbiter;
  import mips_mem_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DW(32), .AW(32)) bus();
  mem_port_arbiter #(.DW(32), .AW(32), .TIMEOUT(4), .DM_PRIORITY(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    bit          dm;
    logic [31:0] rdata;
    bit          use_rdata;
    bit          err;
  } exp_t;
  exp_t sb[$];
  int total = 0, passes = 0, n_access = 0, wait_cnt = 0, ack_lat = 0;
  bit ack_en = 1'b1;
  bit last_dm = 1'b0;
  logic [31:0] mem [0:255] = '{16: 32'h20170008, 17: 32'h12345678, default: 32'h0};

  // Memory model: decides ack for the coming edge, writes enabled lanes on acked stores
  always @(negedge clk) begin
    if (!bus.mem_en) begin
      bus.mem_ack = 1'b0;
      wait_cnt = 0;
    end else if (ack_en && wait_cnt >= ack_lat) begin
      bus.mem_ack = 1'b1;
      bus.mem_rdata = mem[bus.mem_addr[9:2]];
      if (bus.mem_we)
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) mem[bus.mem_addr[9:2]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
      n_access++;
      wait_cnt = 0;
    end else begin
      bus.mem_ack = 1'b0;
      wait_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, want);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit predict(input bit ifr, input bit dmr);
    return (ifr && dmr) ? !last_dm : dmr;
  endfunction

  task automatic expect_tx(input bit dm, input logic [31:0] rd, input bit use_rd, input bit er);
    exp_t e;
    e.dm = dm;
    e.rdata = rd;
    e.use_rdata = use_rd;
    e.err = er;
    sb.push_back(e);
    last_dm = dm;
  endtask

  task automatic wait_ready(input int max, output int k);
    exp_t e;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(bus.if_ready || bus.dm_ready) && k < max);
    if (!(bus.if_ready || bus.dm_ready)) chk("ready_timeout", 32'd0, 32'd1);
    else if (sb.size() == 0) chk("sb_unexpected_ready", 32'd1, 32'd0);
    else begin
      e = sb.pop_front();
      chk("ready_port", {30'd0, bus.if_ready, bus.dm_ready}, e.dm ? 32'd1 : 32'd2);
      if (e.use_rdata) chk("rdata", e.dm ? bus.dm_rdata : bus.if_rdata, e.rdata);
      chk("err", {31'd0, bus.err}, {31'd0, e.err});
    end
  endtask

  initial begin
    int k, na;
    bit d;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_be = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("rst_ready", {30'd0, bus.if_ready, bus.dm_ready}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
    chk("rst_rdata", bus.if_rdata, 32'd0);
    step(); reset = 1'b1;
    // single fetch, ack in first BUSY cycle
    step(); bus.if_req = 1'b1; bus.if_addr = 32'h40; na = n_access;
    expect_tx(1'b0, 32'h20170008, 1'b1, 1'b0);
    @(negedge clk);
    chk("fetch_stall_t0", {31'd0, bus.if_stall}, 32'd1);
    chk("fetch_idle_en", {31'd0, bus.mem_en}, 32'd0);
    @(negedge clk);
    chk("fetch_busy_en", {31'd0, bus.mem_en}, 32'd1);
    chk("fetch_addr", bus.mem_addr, 32'h40);
    chk("fetch_be", {28'd0, bus.mem_be}, 32'hF);
    chk("fetch_we", {31'd0, bus.mem_we}, 32'd0);
    chk("fetch_stall_t1", {31'd0, bus.if_stall}, 32'd1);
    wait_ready(8, k);
    chk("fetch_latency", k, 32'd1);
    chk("fetch_stall_ready", {31'd0, bus.if_stall}, 32'd0);
    step(); bus.if_req = 1'b0;
    chk("fetch_accesses", n_access - na, 32'd1);
    // store byte to an unaligned address
    step(); bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_be = 4'b0001; bus.dm_addr = 32'h1A; bus.dm_wdata = 32'hAB;
    expect_tx(1'b1, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("store_stall", {31'd0, bus.dm_stall}, 32'd1);
    @(negedge clk);
    chk("store_we", {31'd0, bus.mem_we}, 32'd1);
    chk("store_be", {28'd0, bus.mem_be}, 32'h1);
    chk("store_addr", bus.mem_addr, 32'h18);
    chk("store_wdata", bus.mem_wdata, 32'hAB);
    wait_ready(8, k);
    // load it back
    step(); bus.dm_we = 1'b0; bus.dm_addr = 32'h18;
    expect_tx(1'b1, 32'hAB, 1'b1, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("load_be", {28'd0, bus.mem_be}, 32'hF);
    chk("load_we", {31'd0, bus.mem_we}, 32'd0);
    wait_ready(8, k);
    // store with no lanes enabled still completes and leaves rdata alone
    step(); bus.dm_we = 1'b1; bus.dm_be = 4'b0000; bus.dm_wdata = 32'hFFFF_FFFF;
    expect_tx(1'b1, 32'h0, 1'b0, 1'b0);
    wait_ready(8, k);
    chk("store_be0_hold", bus.dm_rdata, 32'hAB);
    step(); bus.dm_we = 1'b0;
    expect_tx(1'b1, 32'hAB, 1'b1, 1'b0);
    wait_ready(8, k);
    step(); bus.dm_req = 1'b0;
    // slow memory, two wait cycles
    ack_lat = 2;
    step(); bus.if_req = 1'b1; bus.if_addr = 32'h44;
    expect_tx(1'b0, 32'h12345678, 1'b1, 1'b0);
    wait_ready(12, k);
    chk("slow2_latency", k, 32'd5);
    step(); bus.if_req = 1'b0;
    // ack on the very cycle the timeout would fire wins
    ack_lat = 3;
    step(); bus.dm_req = 1'b1; bus.dm_addr = 32'h18;
    expect_tx(1'b1, 32'hAB, 1'b1, 1'b0);
    wait_ready(12, k);
    chk("slow3_latency", k, 32'd6);
    step(); bus.dm_req = 1'b0;
    // no ack at all: timeout after 4 BUSY cycles
    ack_en = 1'b0; ack_lat = 0;
    step(); bus.if_req = 1'b1; bus.if_addr = 32'h40;
    expect_tx(1'b0, 32'hDEADBEEF, 1'b1, 1'b1);
    wait_ready(12, k);
    chk("timeout_latency", k, 32'd6);
    step(); bus.if_req = 1'b0; ack_en = 1'b1;
    @(negedge clk);
    chk("timeout_err_clear", {31'd0, bus.err}, 32'd0);
    chk("timeout_idle_en", {31'd0, bus.mem_en}, 32'd0);
    // contention with back-to-back acks: grants must alternate
    step(); bus.if_req = 1'b1; bus.if_addr = 32'h44; bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h18;
    na = n_access;
    for (int i = 0; i < 4; i++) begin
      d = predict(1'b1, 1'b1);
      expect_tx(d, d ? 32'hAB : 32'h12345678, 1'b1, 1'b0);
    end
    for (int i = 0; i < 4; i++) wait_ready(8, k);
    step(); bus.if_req = 1'b0; bus.dm_req = 1'b0;
    chk("contention_accesses", n_access - na, 32'd4);
    // async reset in the middle of an access
    ack_en = 1'b0;
    step(); bus.if_req = 1'b1; bus.if_addr = 32'h40;
    @(negedge clk); @(negedge clk);
    chk("midbusy_en", {31'd0, bus.mem_en}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_en", {31'd0, bus.mem_en}, 32'd0);
    @(negedge clk);
    chk("async_rst_no_ready", {30'd0, bus.if_ready, bus.dm_ready}, 32'd0);
    #2 reset = 1'b1; ack_en = 1'b1; last_dm = 1'b0;
    expect_tx(1'b0, 32'h20170008, 1'b1, 1'b0);
    wait_ready(10, k);
    step(); bus.if_req = 1'b0;
    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
